nes_ram_mirror: RTL and testbench

Parametrised single-port bus RAM for the NES CPU/PPU address space. It replaces fixed 64 KB storage with a configurable physical depth that is mirrored across the full bus address range, such as 2 KB of work RAM mirrored over $0000–$1FFF. It also provides a hardware clear sequencer, a write-protect input, and split read/write data paths with a read-valid strobe, so no internal tristate is used. It sits behind the address decoder on the CPU or PPU bus.

---
 rtl/nes_ram_mirror.sv | 103 ++++++++++
 tb/tb_nes_ram_mirror.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nes_ram_mirror.sv
// nes_ram_mirror: single-port NES bus RAM mirrored across the bus range,
// with a clear sequencer, write protect and a registered read path.
module nes_ram_mirror #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH_LOG2     = 11,
  parameter int unsigned DATA_W         = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              rw_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wp,
  input  logic              clear_req,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              busy,
  output logic              wp_hit
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t state, next_state;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_en;
  logic                  wr_en;
  logic                  wp_en;
  logic                  unused_addr;

  // Upper address bits are deliberately dropped to mirror the array.
  assign idx         = addr[DEPTH_LOG2-1:0];
  assign unused_addr = ^addr;
  assign busy        = (state == CLEAR);

  // State register; reset restarts any clear from index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= next_state;
  end

  // Next state and access decode; a clear request beats a same-cycle access.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wp_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          next_state = CLEAR;
        end else if (!cs_n) begin
          rd_en = rw_n;
          wr_en = !rw_n && !wp;
          wp_en = !rw_n && wp;
        end
      end
      CLEAR: begin
        if (clr_cnt == '1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Clear index; wraps back to zero as the last word is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    else                     clr_cnt <= '0;
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_cnt] <= CLEAR_VAL;
    else if (wr_en)     mem[idx]     <= wdata;
  end

  // Registered read data and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
      wp_hit   <= 1'b0;
    end else begin
      if (rd_en) rdata <= mem[idx];
      rd_valid <= rd_en;
      wp_hit   <= wp_en;
    end
  end

endmodule

// File: tb/tb_nes_ram_mirror.sv
// tb_nes_ram_mirror: directed checks of mirroring, write protect,
// clear sequencing and reset behaviour.
module tb_nes_ram_mirror;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        rw_n;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wp;
  logic        clear_req;
  logic [7:0]  rdata;
  logic        rd_valid;
  logic        busy;
  logic        wp_hit;

  int n_run  = 0;
  int n_fail = 0;

  nes_ram_mirror #(
    .ADDR_W(16),
    .DEPTH_LOG2(11),
    .DATA_W(8),
    .CLEAR_VAL(8'h00),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs_n(cs_n),
    .rw_n(rw_n),
    .addr(addr),
    .wdata(wdata),
    .wp(wp),
    .clear_req(clear_req),
    .rdata(rdata),
    .rd_valid(rd_valid),
    .busy(busy),
    .wp_hit(wp_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cs_n  = 1'b0;
    rw_n  = 1'b0;
    addr  = a;
    wdata = d;
    @(negedge clk);
    cs_n  = 1'b1;
    rw_n  = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [15:0] a,
                    input logic [7:0] e);
    cs_n = 1'b0;
    rw_n = 1'b1;
    addr = a;
    @(negedge clk);
    cs_n = 1'b1;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rdata), 32'(e));
  endtask

  // Counts negedges until busy drops; flags any read output activity.
  task automatic wait_idle(output int cnt, output bit dirty);
    cnt   = 0;
    dirty = 1'b0;
    while (busy && cnt < 5000) begin
      @(negedge clk);
      cnt++;
      if (rd_valid !== 1'b0 || rdata !== 8'h00) dirty = 1'b1;
    end
  endtask

  initial begin
    int  cnt;
    bit  dirty;
    rst_n     = 1'b0;
    cs_n      = 1'b1;
    rw_n      = 1'b1;
    addr      = '0;
    wdata     = '0;
    wp        = 1'b0;
    clear_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_wp_hit", 32'(wp_hit), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    rst_n = 1'b1;
    wait_idle(cnt, dirty);
    chk("reset_clear_len", 32'(cnt), 32'd2048);
    chk("reset_clear_quiet", 32'(dirty), 32'd0);

    rd("rd0000", 16'h0000, 8'h00);
    chk("rd_valid_drop", 32'(rd_valid), 32'h1);
    @(negedge clk);
    chk("rd_valid_low", 32'(rd_valid), 32'h0);
    rd("rd07ff", 16'h07FF, 8'h00);
    rd("rd1234", 16'h1234, 8'h00);

    wr(16'h0801, 8'hA5);
    rd("mir0001", 16'h0001, 8'hA5);
    rd("mir1001", 16'h1001, 8'hA5);
    rd("mir1801", 16'h1801, 8'hA5);
    wr(16'h07FF, 8'h3C);
    rd("mir1fff", 16'h1FFF, 8'h3C);
    @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'h3C);

    wr(16'h0010, 8'h11);
    chk("wp_idle", 32'(wp_hit), 32'h0);
    wp = 1'b1;
    wr(16'h0010, 8'h22);
    chk("wp_hit_pulse", 32'(wp_hit), 32'h1);
    @(negedge clk);
    chk("wp_hit_drop", 32'(wp_hit), 32'h0);
    wr(16'h0010, 8'h33);
    chk("wp_hit_b2b1", 32'(wp_hit), 32'h1);
    wr(16'h0810, 8'h44);
    chk("wp_hit_b2b2", 32'(wp_hit), 32'h1);
    wp = 1'b0;
    rd("wp_rd0010", 16'h0010, 8'h11);

    wr(16'h0020, 8'h55);
    clear_req = 1'b1;
    cs_n      = 1'b0;
    rw_n      = 1'b0;
    addr      = 16'h0020;
    wdata     = 8'h77;
    @(negedge clk);
    clear_req = 1'b0;
    chk("clr_busy_rise", 32'(busy), 32'h1);
    chk("clr_no_wp_hit", 32'(wp_hit), 32'h0);
    rw_n = 1'b1;
    addr = 16'h0001;
    @(negedge clk);
    cs_n = 1'b1;
    chk("busy_rd_valid", 32'(rd_valid), 32'h0);
    chk("busy_rdata_hold", 32'(rdata), 32'h11);
    wait_idle(cnt, dirty);
    chk("clr_len", 32'(cnt + 1), 32'd2048);
    rd("clr_rd0020", 16'h0020, 8'h00);
    rd("clr_rd0001", 16'h0001, 8'h00);

    wr(16'h0001, 8'h01);
    wr(16'h0002, 8'h02);
    wr(16'h0003, 8'h03);
    cs_n = 1'b0;
    rw_n = 1'b1;
    addr = 16'h0001;
    @(negedge clk);
    chk("b2b1_valid", 32'(rd_valid), 32'h1);
    chk("b2b1_data", 32'(rdata), 32'h01);
    addr = 16'h0002;
    @(negedge clk);
    chk("b2b2_valid", 32'(rd_valid), 32'h1);
    chk("b2b2_data", 32'(rdata), 32'h02);
    addr = 16'h0003;
    @(negedge clk);
    cs_n = 1'b1;
    chk("b2b3_valid", 32'(rd_valid), 32'h1);
    chk("b2b3_data", 32'(rdata), 32'h03);
    @(negedge clk);
    chk("b2b_end", 32'(rd_valid), 32'h0);

    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (1000) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", 32'(rdata), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    cs_n  = 1'b0;
    rw_n  = 1'b1;
    addr  = 16'h0003;
    wait_idle(cnt, dirty);
    cs_n  = 1'b1;
    chk("mid_restart_len", 32'(cnt), 32'd2048);
    chk("mid_quiet", 32'(dirty), 32'd0);
    rd("mid_rd0003", 16'h0003, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
